add3_accum_seq: RTL
===================

# add3_accum_seq

Multi-cycle accumulation sequencer built around one shared 6-bit three-operand adder. It accepts a stream of 6-bit words over a valid/ready handshake and adds each word into a `6*DIGITS`-bit accumulator one 6-bit digit per cycle, carrying between digits through operand C. On a word tagged `in_last` it presents the total and a sticky overflow flag on a valid/ready output. It sits between the MAC8 operand front-end and the result path, and turns the single narrow adder into a wide accumulator.

## Interface
- `DIGITS`, default 2: number of 6-bit digits in the accumulator; `ACC_W = 6*DIGITS`; legal range 2..4.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  sequencer can take a word this cycle.
- `in_data`  input  6  unsigned word to accumulate.
- `in_last`  input  1  word closes the burst; qualified by `in_valid`.
- `out_valid`  output  1  result held on `out_sum`/`out_ovf`.
- `out_ready`  input  1  consumer takes the result.
- `out_sum`  output  ACC_W  accumulated total, modulo 2^ACC_W.
- `out_ovf`  output  1  set if any carry left the top digit during the burst.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE (`in_ready=1`)
  - ADD (digit index `d` runs from 0 to DIGITS-1)
  - RESULT (`out_valid=1`)
- IDLE:
  - On `in_valid & in_ready`, register `in_data` into `word_r` and `in_last` into `last_r`.
  - Clear `carry_r`, set `d=0`, go to ADD.
- ADD, one digit per cycle. Adder operands:
  - A = `acc[d]`
  - B = `word_r` when `d==0`, else 0
  - C = `{5'b0, carry_r}`
  - C is never more than 1, so the 7-bit adder result {Carry, Sum} is exact; the controller must never drive C wider.
- ADD update each cycle: `acc[d] <= Sum`, `carry_r <= Carry`.
- ADD on `d==DIGITS-1`:
  - If Carry=1, set `ovf_r` (sticky).
  - Go to RESULT if `last_r`, else to IDLE.
- RESULT:
  - Drive `out_sum=acc` and `out_ovf=ovf_r`.
  - Both stay stable while `out_valid & !out_ready`.
  - On `out_valid & out_ready`, clear `acc` and `ovf_r`, go to IDLE.
- No early exit: all DIGITS cycles always run, including when the carry is 0.
- `in_ready` is low in ADD and RESULT. A word offered then waits; it is not dropped.
- Reset (`rst_n=0` at a clock edge, in any state, including mid-ADD or mid-RESULT):
  - state=IDLE, `acc=0`, `ovf_r=0`, `carry_r=0`, `d=0`, `word_r=0`, `last_r=0`.
  - Output values: `in_ready=1` after the reset edge, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`.
  - A partial burst is discarded.

## Timing
- Word accepted at edge t. ADD occupies cycles t+1 … t+DIGITS.
- Non-last word: `in_ready` is high again in cycle t+DIGITS+1.
- Last word: `out_valid` rises in cycle t+DIGITS+1.
- Peak throughput: one word per DIGITS+1 cycles.
- Result handshake at edge r: `in_ready=1` in cycle r+1. There is no same-cycle output-to-input bypass.
- All outputs are registered or decoded from state only; there is no combinational path from `in_*`/`out_ready` to any output.
- A burst of one word is legal. There is no empty burst: `in_last` always comes with a word.

## Structure
- Shared package `mac8_pkg`:
  - `DIGIT_W=6`
  - state enum `seq_state_t` {IDLE, ADD, RESULT}
- One sub-module: a single instance of `reversible_6bit_adder`, with operands muxed per digit as above. No second adder.
- Accumulator: a DIGITS×6 register array indexed by `d`.
- `d` counter width: `$clog2(DIGITS)`.

## Test plan
- Reset: hold `rst_n=0` 2 cycles, release -> `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`.
- Single word (DIGITS=2): in_data=63 with in_last, accepted at t -> `out_valid` in cycle t+3, `out_sum=63`, `out_ovf=0`.
- Carry into digit 1: words 63 then 1 (last) -> `out_sum=64` (acc[1]=1, acc[0]=0), `out_ovf=0`.
- Overflow:
  - 65 words of 63 -> `out_sum=4095`, `out_ovf=0`.
  - 66 words of 63 -> `out_sum=62`, `out_ovf=1`.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in RESULT -> `out_valid`, `out_sum` and `out_ovf` stable, `in_ready=0`, and the pending input word is not consumed.
  - After the handshake, burst {5 (last)} -> `out_sum=5`, showing acc was cleared.
- Reset mid-operation: assert `rst_n=0` during ADD d=1 of the second word -> next cycle state IDLE, `acc=0`; following burst {7 (last)} -> `out_sum=7`, `out_ovf=0`.

Source files
------------

// File: rtl/mac8_pkg.sv
// Shared definitions for the MAC8 accumulation path.
//   DIGIT_W     : width of one accumulator digit / adder operand
//   seq_state_t : sequencer states (IDLE, ADD, RESULT)
package mac8_pkg;

   localparam int unsigned DIGIT_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      RESULT
   } seq_state_t;

endpackage

// File: rtl/reversible_6bit_adder.sv
// Three-operand 6-bit adder.
//   a, b, c : unsigned operands (c is at most 1 when used by the sequencer,
//             so the 7-bit result {carry, sum} is always exact)
//   sum     : low 6 bits of a + b + c
//   carry   : bit 6 of a + b + c
module reversible_6bit_adder
   import mac8_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic [DIGIT_W-1:0] c,
   output logic [DIGIT_W-1:0] sum,
   output logic               carry
);

   logic [DIGIT_W:0] total;

   always_comb begin
      total = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(c);
      sum   = total[DIGIT_W-1:0];
      carry = total[DIGIT_W];
   end

endmodule

// File: rtl/add3_accum_seq.sv
// Multi-cycle accumulation sequencer: adds a stream of 6-bit words into a
// 6*DIGITS-bit accumulator, one digit per cycle, through a single shared
// three-operand adder. A word tagged in_last closes the burst and the total
// plus a sticky overflow flag are presented on a valid/ready output.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input word handshake; in_data word, in_last closes burst
//   out_valid/out_ready : result handshake; out_sum total, out_ovf sticky overflow
//   busy                : high whenever the sequencer is not IDLE
module add3_accum_seq
   import mac8_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DIGIT_W-1:0]          in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DIGIT_W*DIGITS-1:0]   out_sum,
   output logic                        out_ovf,
   output logic                        busy
);

   localparam int unsigned DW = $clog2(DIGITS);
   localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

   seq_state_t         state_q, state_d;
   logic [DIGIT_W-1:0] acc_q [DIGITS];
   logic [DIGIT_W-1:0] acc_d [DIGITS];
   logic               ovf_q, ovf_d;
   logic               carry_q, carry_d;
   logic [DW-1:0]      d_q, d_d;
   logic [DIGIT_W-1:0] word_q, word_d;
   logic               last_q, last_d;

   logic [DIGIT_W-1:0] op_a, op_b, op_c, add_sum;
   logic               add_carry;

   // Operand mux: the word enters only at digit 0; upper digits just
   // absorb the ripple carry through operand C.
   always_comb begin
      op_a = acc_q[d_q];
      op_b = (d_q == '0) ? word_q : '0;
      op_c = {{(DIGIT_W-1){1'b0}}, carry_q};
   end

   reversible_6bit_adder u_adder (
      .a     (op_a),
      .b     (op_b),
      .c     (op_c),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         for (int unsigned i = 0; i < DIGITS; i++) acc_q[i] <= '0;
         ovf_q   <= 1'b0;
         carry_q <= 1'b0;
         d_q     <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
         d_q     <= d_d;
         word_q  <= word_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = ADD;
         ADD:     if (d_q == D_LAST) state_d = last_q ? RESULT : IDLE;
         RESULT:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      carry_d = carry_q;
      d_d     = d_q;
      word_d  = word_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_data;
               last_d  = in_last;
               carry_d = 1'b0;
               d_d     = '0;
            end
         end
         ADD: begin
            acc_d[d_q] = add_sum;
            carry_d    = add_carry;
            if (d_q == D_LAST) begin
               d_d = '0;
               if (add_carry) ovf_d = 1'b1;
            end else begin
               d_d = d_q + DW'(1);
            end
         end
         RESULT: begin
            if (out_ready) begin
               for (int unsigned i = 0; i < DIGITS; i++) acc_d[i] = '0;
               ovf_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state and registers only
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == RESULT);
      busy      = (state_q != IDLE);
      out_ovf   = ovf_q;
      out_sum   = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         out_sum[i*DIGIT_W +: DIGIT_W] = acc_q[i];
   end

endmodule
